// File: rtl/player_dir_input_encoder_pkg.sv
// Shared direction codes, direction type and encoder state encoding.
// Used by the input encoder, the direction filter and the movement logic.
package player_dir_input_encoder_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b11;
    localparam dir_t DIR_LEFT  = 2'b10;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    // Bit order of press vectors: [3]=up [2]=right [1]=down [0]=left.
    // Fixed priority UP > RIGHT > DOWN > LEFT when several fire together.
    function automatic dir_t encode_press(input logic [3:0] p);
        dir_t d;
        d = DIR_UP;
        case (1'b1)
            p[3]:    d = DIR_UP;
            p[2]:    d = DIR_RIGHT;
            p[1]:    d = DIR_DOWN;
            p[0]:    d = DIR_LEFT;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/player_dir_input_encoder_debouncer.sv
// button_debouncer: 2-FF synchroniser, stability counter, debounced
// level and a registered one-cycle rise pulse for one raw button.
// Ports: clk, reset (sync, active-high), btn_raw (async input),
//        level (debounced level), rise (pulse on debounced 0->1).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_prev_q, level_prev_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        level_d      = level_q;
        cnt_d        = cnt_q;
        level_prev_d = level_q;
        rise_d       = level_q & ~level_prev_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Input has differed for DEBOUNCE_CYCLES cycles: accept it.
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            rise_q       <= rise_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/player_dir_input_encoder.sv
// Player direction input encoder: debounces four buttons and holds the
// latest requested direction pending until a move_tick consumes it.
// Ports: clk, reset (sync, active-high), btn_up/right/down/left (raw),
//        move_tick (consume strobe), direction_req, req_valid, press_seen.
// Option: define PLAYER_INPUT_HOLD_EN to re-request held keys per tick.
module player_dir_input_encoder
    import player_dir_input_encoder_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_W           = 19,
    parameter dir_t INIT_DIR        = DIR_DOWN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       move_tick,
    output logic [1:0] direction_req,
    output logic       req_valid,
    output logic       press_seen
);

    logic [3:0] btn_raw;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] press;
    logic       any_press;

    state_e state_q, state_d;
    dir_t   dir_q, dir_d;
    logic   press_seen_q, press_seen_d;

    assign btn_raw = {btn_up, btn_right, btn_down, btn_left};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_raw[i]),
            .level  (level[i]),
            .rise   (rise[i])
        );
    end

`ifdef PLAYER_INPUT_HOLD_EN
    // Set for one cycle after a move_tick consumed a request, so every
    // still-held key fires a fresh press.
    logic rearm_q, rearm_d;

    assign press = rise | (level & {4{rearm_q}});

    always_comb begin
        rearm_d = (state_q == ST_PENDING) && move_tick && !any_press;
    end

    always_ff @(posedge clk) begin
        if (reset) rearm_q <= 1'b0;
        else       rearm_q <= rearm_d;
    end
`else
    logic level_unused;

    assign level_unused = ^level;
    assign press        = rise;
`endif

    assign any_press = |press;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: a press always wins over a coincident move_tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_press) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (any_press)      state_d = ST_PENDING;
                else if (move_tick) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        req_valid = (state_q == ST_PENDING);
    end

    // Latched direction and debug pulse.
    always_comb begin
        dir_d        = dir_q;
        press_seen_d = any_press;
        if (any_press) dir_d = encode_press(press);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q        <= INIT_DIR;
            press_seen_q <= 1'b0;
        end else begin
            dir_q        <= dir_d;
            press_seen_q <= press_seen_d;
        end
    end

    assign direction_req = dir_q;
    assign press_seen    = press_seen_q;

endmodule

// File: tb/tb_player_dir_input_encoder.sv
// Self-checking bench for player_dir_input_encoder (DEBOUNCE_CYCLES=4).
// Expected outputs are queued per driven cycle and checked after the edge.
module tb_player_dir_input_encoder;

`ifdef PLAYER_INPUT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       btn_up, btn_right, btn_down, btn_left;
    logic       move_tick;
    logic [1:0] direction_req;
    logic       req_valid;
    logic       press_seen;

    player_dir_input_encoder #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .INIT_DIR       (2'b11)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up       (btn_up),
        .btn_right    (btn_right),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .move_tick    (move_tick),
        .direction_req(direction_req),
        .req_valid    (req_valid),
        .press_seen   (press_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;   // {up,right,down,left}
        logic       tick;
        logic       rst;
        logic       chk;
        logic [1:0] dir;
        logic       vld;
        logic       seen;
    } vec_t;

    typedef struct {
        int         id;
        logic       chk;
        logic [1:0] dir;
        logic       vld;
        logic       seen;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    task automatic step(input logic [3:0] b, input logic t, input logic r,
                        input logic [1:0] d, input logic v, input logic s);
        exp_t e;
        @(negedge clk);
        {btn_up, btn_right, btn_down, btn_left} = b;
        move_tick = t;
        reset     = r;
        e.id   = step_id;
        e.chk  = 1'b1;
        e.dir  = d;
        e.vld  = v;
        e.seen = s;
        exp_q.push_back(e);
        step_id++;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                checks++;
                if (direction_req !== e.dir || req_valid !== e.vld ||
                    press_seen !== e.seen) begin
                    errors++;
                    $display("FAIL step%0d: got dir=%b vld=%b seen=%b want dir=%b vld=%b seen=%b",
                             e.id, direction_req, req_valid, press_seen,
                             e.dir, e.vld, e.seen);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        move_tick = 1'b0;
        {btn_up, btn_right, btn_down, btn_left} = 4'b0000;

        // Reset, idle, then right press / consume.
        tbl.push_back('{4'b0000, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0});
        for (int i = 0; i < 20; i++)
            tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0});
        for (int i = 0; i < 7; i++)
            tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1});
        tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0});
        tbl.push_back('{4'b0100, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b1, 2'b01, HOLD, HOLD});
        tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b1, 2'b01, HOLD, 1'b0});

        foreach (tbl[i])
            step(tbl[i].btn, tbl[i].tick, tbl[i].rst,
                 tbl[i].dir, tbl[i].vld, tbl[i].seen);

        // Release right: releases produce nothing.
        for (int i = 0; i < 10; i++) step(4'b0000, 0, 0, 2'b01, HOLD, 0);
        // Tick clears any pending request; tick in IDLE has no effect.
        step(4'b0000, 1, 0, 2'b01, 0, 0);
        step(4'b0000, 1, 0, 2'b01, 0, 0);
        step(4'b0000, 0, 0, 2'b01, 0, 0);

        // 3-cycle glitch on left is rejected.
        for (int i = 0; i < 3; i++)  step(4'b0001, 0, 0, 2'b01, 0, 0);
        for (int i = 0; i < 12; i++) step(4'b0000, 0, 0, 2'b01, 0, 0);

        // Up and down together: UP has priority.
        for (int i = 0; i < 7; i++) step(4'b1010, 0, 0, 2'b01, 0, 0);
        step(4'b1010, 0, 0, 2'b00, 1, 1);
        step(4'b1010, 0, 0, 2'b00, 1, 0);
        step(4'b1010, 0, 0, 2'b00, 1, 0);

        // Left while PENDING overwrites.
        for (int i = 0; i < 7; i++) step(4'b1011, 0, 0, 2'b00, 1, 0);
        step(4'b1011, 0, 0, 2'b10, 1, 1);
        step(4'b1011, 0, 0, 2'b10, 1, 0);
        for (int i = 0; i < 10; i++) step(4'b0000, 0, 0, 2'b10, 1, 0);

        // Press coincident with move_tick: press wins.
        for (int i = 0; i < 7; i++) step(4'b0100, 0, 0, 2'b10, 1, 0);
        step(4'b0100, 1, 0, 2'b01, 1, 1);
        step(4'b0100, 0, 0, 2'b01, 1, 0);

        // Reset while PENDING, button held through reset.
        step(4'b0100, 0, 1, 2'b11, 0, 0);
        for (int i = 0; i < 7; i++) step(4'b0100, 0, 0, 2'b11, 0, 0);
        step(4'b0100, 0, 0, 2'b01, 1, 1);
        for (int i = 0; i < 10; i++) step(4'b0000, 0, 0, 2'b01, 1, 0);
        step(4'b0000, 1, 0, 2'b01, 0, 0);

        // Up held across three move_ticks.
        for (int i = 0; i < 7; i++) step(4'b1000, 0, 0, 2'b01, 0, 0);
        step(4'b1000, 0, 0, 2'b00, 1, 1);
        step(4'b1000, 0, 0, 2'b00, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(4'b1000, 1, 0, 2'b00, 0, 0);
            step(4'b1000, 0, 0, 2'b00, HOLD, HOLD);
            for (int i = 0; i < 3; i++)
                step(4'b1000, 0, 0, 2'b00, HOLD, 0);
        end
        for (int i = 0; i < 8; i++) step(4'b0000, 0, 0, 2'b00, HOLD, 0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_dir_input_encoder.md
Name: player_dir_input_encoder

Overview:
- Producer side of the player direction interface: turns four raw direction buttons into the 2-bit direction request that the per-player direction filter consumes.
- Per button: synchronises, debounces and edge-detects the input.
- Latches the most recent request and holds it pending until the game logic consumes it on a move tick.
- One instance per player, between the board buttons and the direction filter.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); minimum 2.
- CNT_W, 19, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.
- INIT_DIR, 2'b11, direction_req value after reset (player 1 starts DOWN; player 2 instance uses 2'b00 UP).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_up  in  1  raw button, active-high, asynchronous to clk
- btn_right  in  1  raw button, active-high, asynchronous to clk
- btn_down  in  1  raw button, active-high, asynchronous to clk
- btn_left  in  1  raw button, active-high, asynchronous to clk
- move_tick  in  1  one-cycle strobe; game consumes the pending request this cycle
- direction_req  out  2  latched requested direction: 00 UP, 01 RIGHT, 11 DOWN, 10 LEFT
- req_valid  out  1  high while a request is pending (not yet consumed)
- press_seen  out  1  one-cycle pulse on any accepted press, for debug LEDs

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high, port name reset.
- Reset values: direction_req=INIT_DIR, req_valid=0, press_seen=0; all synchronisers, debounced levels and counters cleared to 0.
- Synchroniser: 2-FF chain per button.
- Debounce, per button:
  - Counter clears whenever the synchronised input equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press event: rising edge of a debounced level (previous 0, now 1). Releases generate nothing.
- Latency: raw rise held from cycle 0 gives req_valid=1 and updated direction_req at cycle 2+DEBOUNCE_CYCLES+1.
- State machine, two states:
  - IDLE (req_valid=0): a press event loads direction_req, goes to PENDING and pulses press_seen.
  - PENDING (req_valid=1): a further press overwrites direction_req (most recent wins) and stays in PENDING. move_tick without a press returns to IDLE; direction_req holds its value.
- Simultaneous events:
  - Multiple press events in one cycle use fixed priority UP > RIGHT > DOWN > LEFT.
  - Press and move_tick in the same cycle: the press wins. New value is loaded and state stays PENDING (req_valid stays 1).
- No reversal filtering here; the downstream filter owns that.
- move_tick in IDLE: no effect.
- Reset asserted mid-debounce or while PENDING: everything returns to reset values the next edge. A button held through reset deasserting produces a press event DEBOUNCE_CYCLES+2 cycles later.

Optional Feature:
- Macro: PLAYER_INPUT_HOLD_EN.
- Defined: a button whose debounced level is still high re-arms after each move_tick. The cycle after a consuming move_tick, that button generates a fresh press event, same priority rules, so a held key keeps requesting every tick.
- Undefined: only rising edges generate press events; holding a key yields exactly one request.

Decomposition:
- Shared package:
  - direction code constants DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_DOWN=2'b11, DIR_LEFT=2'b10, used by this block, the direction filter and the movement logic;
  - 2-bit direction typedef;
  - state encoding constants ST_IDLE, ST_PENDING.
- Sub-module: button_debouncer (synchroniser + counter + debounced level + rise pulse), parameterised by DEBOUNCE_CYCLES/CNT_W, instantiated four times.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3, INIT_DIR=2'b11):
- Reset then idle 20 cycles -> direction_req=11, req_valid=0, press_seen never pulses.
- btn_right high from cycle 0, held -> cycle 7: direction_req=01, req_valid=1, press_seen=1 for one cycle. move_tick at cycle 10 -> req_valid=0 at cycle 11, direction_req stays 01.
- btn_left 3-cycle glitch -> no press event, direction_req unchanged, req_valid=0.
- btn_up and btn_down rise same cycle -> direction_req=00. Later btn_left press while PENDING -> direction_req=10, req_valid stays 1.
- Press event coincident with move_tick -> req_valid stays 1, direction_req=new value. Reset pulse while PENDING -> direction_req=11, req_valid=0 next cycle.
- With PLAYER_INPUT_HOLD_EN, btn_up held across three move_ticks -> req_valid re-asserts the cycle after each tick with direction_req=00. Without the macro -> a single request only.
